seq_subtractor16: RTL and testbench

SEQ_SUBTRACTOR16 -- requirements
Module: seq_subtractor16

---
 rtl/seq_subtractor16_if.sv | 26 ++
 rtl/seq_subtractor16.sv | 114 +++++++++++
 tb/tb_seq_subtractor16.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/seq_subtractor16_if.sv
// Operand/result bundle for the sequential slice-wise subtractor.
// The master issues start with operands; the slave returns status and results.
interface seq_subtractor16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf, zero
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf, zero
  );
endinterface

// File: rtl/seq_subtractor16.sv
// Multi-cycle subtractor: computes a - b - bin one SLICE-bit chunk per clock, LSB first.
// Results and flags are only published on the completing edge, together with a done pulse.
module seq_subtractor16 #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_subtractor16_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic             load, step, finish;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic             borrow_reg, borrow_next;
  logic [CW-1:0]    cnt_reg;
  logic [SLICE-1:0] a_sl [NSLICE];
  logic [SLICE-1:0] b_sl [NSLICE];
  logic [SLICE:0]   sl_res;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg, ovf_reg, zero_reg, done_reg;

  // Slice views of the latched operands, and the accumulator with only the active slice replaced.
  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign a_sl[gi] = a_reg[gi*SLICE +: SLICE];
      assign b_sl[gi] = b_reg[gi*SLICE +: SLICE];
      assign acc_next[gi*SLICE +: SLICE] = (cnt_reg == CW'(gi)) ? sl_res[SLICE-1:0]
                                                                 : acc_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  // Extra top bit of the slice result is the borrow into the next slice.
  assign sl_res      = {1'b0, a_sl[cnt_reg]} - {1'b0, b_sl[cnt_reg]} - {{SLICE{1'b0}}, borrow_reg};
  assign borrow_next = sl_res[SLICE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_reg == CW'(NSLICE - 1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= finish;
      if (load) begin
        a_reg      <= bus.a;
        b_reg      <= bus.b;
        borrow_reg <= bus.bin;
        cnt_reg    <= '0;
        acc_reg    <= '0;
      end else if (step) begin
        acc_reg    <= acc_next;
        borrow_reg <= borrow_next;
        cnt_reg    <= cnt_reg + CW'(1);
      end
      // Overflow only possible when operand signs differ and the result sign leaves a's sign.
      if (finish) begin
        diff_reg <= acc_next;
        bout_reg <= borrow_next;
        ovf_reg  <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (acc_next[WIDTH-1] != a_reg[WIDTH-1]);
        zero_reg <= (acc_next == '0);
      end
    end
  end

  assign bus.busy = (state_reg == RUN);
  assign bus.done = done_reg;
  assign bus.diff = diff_reg;
  assign bus.bout = bout_reg;
  assign bus.ovf  = ovf_reg;
  assign bus.zero = zero_reg;
endmodule

// File: tb/tb_seq_subtractor16.sv
// Scoreboard bench for seq_subtractor16: stimulus pushes expected results, a negedge monitor checks them.
module tb_seq_subtractor16;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        q[$];
  logic [18:0] last_out = '0;

  seq_subtractor16_if #(.WIDTH(16)) bus ();

  seq_subtractor16 #(.WIDTH(16), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: plain integer arithmetic on the whole words.
  function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic bin);
    exp_t e;
    int   ua, ub, sd;
    ua     = int'(a);
    ub     = int'(b);
    sd     = int'($signed(a)) - int'($signed(b)) - int'(bin);
    e.a    = a;
    e.b    = b;
    e.bin  = bin;
    e.diff = 16'((ua - ub - int'(bin)) & 32'hffff);
    e.bout = (ua < ub + int'(bin));
    e.ovf  = (sd > 32767) || (sd < -32768);
    e.zero = (e.diff == 16'h0000);
    e.cyc  = 0;
    return e;
  endfunction

  // Monitor: every done pops one expectation; between dones results must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        chk("busy_in_done", 32'(bus.busy), 32'(0));
        if (q.size() == 0) begin
          chk("spurious_done", 32'(bus.done), 32'(0));
        end else begin
          exp_t e;
          e = q.pop_front();
          $display("txn: a=%h b=%h bin=%0d -> diff=%h bout=%0d ovf=%0d zero=%0d at cycle %0d",
                   e.a, e.b, e.bin, bus.diff, bus.bout, bus.ovf, bus.zero, cyc);
          chk("diff", 32'(bus.diff), 32'(e.diff));
          chk("bout", 32'(bus.bout), 32'(e.bout));
          chk("ovf", 32'(bus.ovf), 32'(e.ovf));
          chk("zero", 32'(bus.zero), 32'(e.zero));
          chk("latency", cyc, e.cyc);
          last_out = {e.diff, e.bout, e.ovf, e.zero};
        end
      end else begin
        chk("hold", 32'({bus.diff, bus.bout, bus.ovf, bus.zero}), 32'(last_out));
      end
    end
  end

  // Called at a negedge with the DUT idle; acceptance happens on the next posedge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bin);
    exp_t e;
    e     = model(a, b, bin);
    e.cyc = cyc + 5;
    q.push_back(e);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    bus.bin   = 1'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(bus.done), 32'(1));
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hffff;
      2:       return 16'h8000;
      3:       return 16'h7fff;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
    chk({tag, "_done"}, 32'(bus.done), 32'(0));
    chk({tag, "_diff"}, 32'(bus.diff), 32'(0));
    chk({tag, "_bout"}, 32'(bus.bout), 32'(0));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(0));
    chk({tag, "_zero"}, 32'(bus.zero), 32'(0));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2 check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, each issued in the previous done cycle.
    issue(16'h7eed, 16'h3333, 1'b0); wait_done();
    issue(16'h8888, 16'h8abc, 1'b0); wait_done();
    issue(16'h8888, 16'h8abc, 1'b1); wait_done();
    issue(16'h8000, 16'h0001, 1'b0); wait_done();
    issue(16'h1234, 16'h1234, 1'b0); wait_done();
    issue(16'h0000, 16'h0000, 1'b1); wait_done();
    repeat (3) @(negedge clk);

    // Start during RUN must be ignored.
    issue(16'h5a5a, 16'h1111, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'hffff;
    bus.b     = 16'h0001;
    bus.bin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);

    // Reset mid-run aborts without a done.
    issue(16'hc3c3, 16'h0f0f, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("abort");
    q.delete();
    last_out = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(16'h4321, 16'h1234, 1'b1); wait_done();

    // Random operations with random idle gaps (gap 0 = back-to-back).
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      issue(pick_operand(), pick_operand(), 1'($urandom));
      wait_done();
    end

    repeat (6) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
